lf_edge_interval_ssp: RTL

LF_EDGE_INTERVAL_SSP -- requirements
Module: lf_edge_interval_ssp

---
 rtl/lf_edge_interval_ssp_pkg.sv | 20 ++
 rtl/lf_edge_interval_ssp_if.sv | 11 +
 rtl/lf_record_fifo.sv | 47 ++++
 rtl/lf_edge_interval_ssp.sv | 161 ++++++++++++++++
 4 files changed

// File: rtl/lf_edge_interval_ssp_pkg.sv
// Shared constants and types for the edge-interval capture and SSP serializer.
package lf_edge_interval_ssp_pkg;

    localparam int REC_W = 16;
    localparam int INT_W = 15;
    localparam logic [INT_W-1:0] INT_SAT = 15'h7FFF;

    typedef enum logic [1:0] {
        SER_IDLE,
        SER_LOAD,
        SER_SHIFT
    } ser_state_t;

    // A record carries the edge level in its MSB and the interval below it.
    function automatic logic [REC_W-1:0] make_record(input logic level,
                                                     input logic [INT_W-1:0] interval);
        return {level, interval};
    endfunction

endpackage

// File: rtl/lf_edge_interval_ssp_if.sv
// Three-wire SSP link from the capture block towards the ARM.
interface lf_edge_interval_ssp_if;

    logic ssp_clk;
    logic ssp_frame;
    logic ssp_din;

    modport master (output ssp_clk, ssp_frame, ssp_din);
    modport slave  (input  ssp_clk, ssp_frame, ssp_din);

endinterface

// File: rtl/lf_record_fifo.sv
// Small synchronous record FIFO; a pop on a full FIFO frees room for a same-cycle push.
module lf_record_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/lf_edge_interval_ssp.sv
// Measures cycles between edge-detector events, queues {level, interval} records
// and shifts them MSB first to the ARM over SSP.
module lf_edge_interval_ssp
    import lf_edge_interval_ssp_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int SSP_HALF   = 4
) (
    input  logic                          pck0,
    input  logic                          rst_n,
    input  logic                          enable,
    input  logic                          edge_toggle,
    input  logic                          edge_state,
    lf_edge_interval_ssp_if.master        ssp,
    output logic                          overflow
);

    localparam int DIV_W = (2 * SSP_HALF > 2) ? $clog2(2 * SSP_HALF) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * SSP_HALF - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(SSP_HALF);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [INT_W-1:0] INT_ONE  = INT_W'(1);

    logic             tog_q;
    logic             evt;
    logic [INT_W-1:0] interval_cnt;
    logic [REC_W-1:0] rec_q;
    logic             rec_valid_q;

    logic [REC_W-1:0] fifo_dout;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;

    ser_state_t       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [REC_W-1:0] shreg_q, shreg_d;
    logic             in_shift;
    logic             ssp_clk_q, ssp_clk_d;
    logic             ssp_frame_q, ssp_frame_d;
    logic             ssp_din_q, ssp_din_d;

    // The toggle is tracked even in reset so release never looks like an edge.
    always_ff @(posedge pck0) begin
        tog_q <= edge_toggle;
    end

    assign evt = (edge_toggle != tog_q) && enable;

    always_ff @(posedge pck0) begin
        if (!rst_n || !enable) begin
            interval_cnt <= '0;
        end else if (evt) begin
            interval_cnt <= INT_ONE;
        end else if (interval_cnt != INT_SAT) begin
            interval_cnt <= interval_cnt + INT_ONE;
        end
    end

    always_ff @(posedge pck0) begin
        if (!rst_n) begin
            rec_valid_q <= 1'b0;
            rec_q       <= '0;
        end else begin
            rec_valid_q <= evt;
            if (evt) rec_q <= make_record(edge_state, interval_cnt);
        end
    end

    // A record is lost only when the FIFO is full and no pop frees a slot.
    always_ff @(posedge pck0) begin
        if (!rst_n || !enable) begin
            overflow <= 1'b0;
        end else if (rec_valid_q && fifo_full && !fifo_pop) begin
            overflow <= 1'b1;
        end
    end

    lf_record_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (REC_W)
    ) u_fifo (
        .clk       (pck0),
        .rst_n     (rst_n),
        .flush     (!enable),
        .push      (rec_valid_q),
        .push_data (rec_q),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        fifo_pop = 1'b0;
        case (state_q)
            SER_IDLE: begin
                if (!fifo_empty) state_d = SER_LOAD;
            end
            SER_LOAD: begin
                div_d = '0;
                bit_d = 4'd15;
                // A flush landing on the IDLE->LOAD edge leaves nothing to load.
                if (fifo_empty) begin
                    state_d = SER_IDLE;
                end else begin
                    fifo_pop = 1'b1;
                    shreg_d  = fifo_dout;
                    state_d  = SER_SHIFT;
                end
            end
            SER_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shreg_d = {shreg_q[REC_W-2:0], 1'b0};
                    bit_d   = bit_q - 4'd1;
                    if (bit_q == 4'd0) state_d = fifo_empty ? SER_IDLE : SER_LOAD;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end
            default: state_d = SER_IDLE;
        endcase

        // Outputs follow the next state so the pins come straight from flops.
        in_shift    = (state_d == SER_SHIFT);
        ssp_clk_d   = in_shift && (div_d >= DIV_HALF);
        ssp_frame_d = in_shift && (bit_d == 4'd15);
        ssp_din_d   = in_shift && shreg_d[REC_W-1];
    end

    always_ff @(posedge pck0) begin
        if (!rst_n) begin
            state_q     <= SER_IDLE;
            div_q       <= '0;
            bit_q       <= '0;
            shreg_q     <= '0;
            ssp_clk_q   <= 1'b0;
            ssp_frame_q <= 1'b0;
            ssp_din_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_q       <= div_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            ssp_clk_q   <= ssp_clk_d;
            ssp_frame_q <= ssp_frame_d;
            ssp_din_q   <= ssp_din_d;
        end
    end

    assign ssp.ssp_clk   = ssp_clk_q;
    assign ssp.ssp_frame = ssp_frame_q;
    assign ssp.ssp_din   = ssp_din_q;

endmodule
